vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port synchronous video RAM between the CRTC character fetch path and the CPU bus. Video fetches get strict priority and fixed latency. CPU reads and writes are queued and acknowledged with a one-cycle ready pulse. Sits between the video block's VRAM address/data pins, the CPU data bus decode and the VRAM macro, all on the FPGA clock.

## Interface
- ADDR_WIDTH, 13, VRAM word address width (8-bit words)
- CLK  in  1  FPGA clock; all state changes on rising edge
- RESET_n  in  1  asynchronous active-low reset
- VID_REQ  in  1  video fetch request, single-cycle pulse
- VID_A  in  ADDR_WIDTH  video fetch address, valid with VID_REQ
- VID_Q  out  8  fetched video byte
- VID_VALID  out  1  one-cycle strobe; VID_Q valid while high
- CPU_SEL  in  1  CPU access request; held high until CPU_RDY seen, then dropped
- CPU_R_W_n  in  1  1 = read, 0 = write; sampled with request
- CPU_A  in  ADDR_WIDTH  CPU address; sampled with request
- CPU_DI  in  8  CPU write data; sampled with request
- CPU_DO  out  8  CPU read data; holds until next read completes
- CPU_RDY  out  1  one-cycle completion pulse
- RAM_A  out  ADDR_WIDTH  VRAM address, registered
- RAM_D  out  8  VRAM write data, registered
- RAM_WE  out  1  VRAM write enable, registered, one cycle per write
- RAM_Q  in  8  VRAM read data, valid one edge after address is sampled

## Operation
- Slot per cycle; at each edge one of: video read, buffer drain (write), CPU read/write, idle.
- Grant priority: VID_REQ > pending CPU write (buffer drain) > pending CPU read/write.
- CPU FSM: C_IDLE -> C_PEND (CPU_SEL high in C_IDLE: latch A, DI, R_W_n) -> on grant: read -> C_RD1 -> C_RD2 -> C_ACK; write -> C_ACK. C_ACK -> C_HOLD (one cycle) -> C_IDLE when CPU_SEL low; stays in C_HOLD while CPU_SEL high. A new request is accepted only in C_IDLE.
- CPU_RDY high exactly while FSM is in C_ACK.
- Video read: no internal queue. A VID_REQ arriving while a previous video read is in flight is granted normally; the reads pipeline back-to-back.
- CPU accesses wait indefinitely while VID_REQ is asserted every cycle. There is no starvation guard.
- RAM_WE is high only in the cycle after a write grant. It is low after every other grant and when idle.
- Reset mid-operation: all in-flight accesses are discarded. The FSM returns to C_IDLE and the buffer empties. No partial write reaches the RAM after reset asserts.
- Reset values: RAM_A 0, RAM_D 0, RAM_WE 0, VID_Q 0x00, VID_VALID 0, CPU_DO 0x00, CPU_RDY 0.

## Timing
- Video: VID_REQ sampled at edge k -> RAM_A = VID_A after edge k -> RAM samples at k+1 -> VID_Q captured at k+2. VID_VALID is high for the cycle after edge k+2. The latency is fixed at 2 edges and is independent of CPU activity.
- CPU read, uncontended: CPU_SEL sampled at edge 0 -> granted at edge 1 -> CPU_DO captured at edge 3. CPU_RDY is high in the cycle after edge 3.
- CPU write, unbuffered, uncontended: latch at edge 0, grant at edge 1. RAM_WE and CPU_RDY are both high in the cycle after edge 1.
- Each cycle with VID_REQ high at a grant edge delays a pending CPU grant by exactly one cycle.
- A read after a write to the same address returns the new data. The write slot always precedes the read slot.

## Configuration
- VRAM_ARB_WRITE_BUFFER_EN defined: one-entry posted-write buffer.
  - CPU write with buffer empty: latched into the buffer at edge 0, C_ACK entered at edge 0, CPU_RDY high in the cycle after edge 0.
  - The buffer drains at the first slot not taken by video.
  - CPU write with buffer full: waits in C_PEND until the buffer drains.
  - CPU read with buffer full: waits until the buffer drains, then competes normally.
- Undefined: no buffer. Writes follow the unbuffered path above, and drain priority never applies.

## Test plan
- Reset: hold RESET_n low mid-write -> every output at its reset value, RAM_WE never high after the reset edge, FSM idle after release.
- Video only: VID_REQ pulses at A=0x0100, 0x0101 on consecutive cycles, RAM preloaded 0x41/0x42 -> VID_VALID on two consecutive cycles with VID_Q 0x41 then 0x42, each 2 edges after its request.
- CPU read: RAM[0x1FFF]=0x5A, CPU_SEL read A=0x1FFF -> CPU_RDY one cycle after edge 3, CPU_DO=0x5A, stays 0x5A after CPU_SEL drops.
- Contention: CPU read pending while VID_REQ is high for 5 consecutive cycles -> CPU grant delayed exactly 5 cycles; all 5 VID_VALID strobes keep 2-edge latency.
- Write then read: write 0xC3 to 0x0800, then read 0x0800 -> RAM_WE one cycle with RAM_A=0x0800, RAM_D=0xC3; read returns 0xC3.
  - With VRAM_ARB_WRITE_BUFFER_EN: write CPU_RDY in the cycle after edge 0, and the read still returns 0xC3.
- Buffer full (VRAM_ARB_WRITE_BUFFER_EN, VID_REQ held high): two back-to-back writes -> first acknowledged immediately, second held in C_PEND until VID_REQ drops; both writes reach RAM in issue order.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has strict priority with fixed 2-edge latency, CPU accesses queue behind it.
// Define VRAM_ARB_WRITE_BUFFER_EN to add a one-entry posted-write buffer for CPU writes.
module vram_arbiter #(
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  CLK,
   input  logic                  RESET_n,
   input  logic                  VID_REQ,
   input  logic [ADDR_WIDTH-1:0] VID_A,
   output logic [7:0]            VID_Q,
   output logic                  VID_VALID,
   input  logic                  CPU_SEL,
   input  logic                  CPU_R_W_n,
   input  logic [ADDR_WIDTH-1:0] CPU_A,
   input  logic [7:0]            CPU_DI,
   output logic [7:0]            CPU_DO,
   output logic                  CPU_RDY,
   output logic [ADDR_WIDTH-1:0] RAM_A,
   output logic [7:0]            RAM_D,
   output logic                  RAM_WE,
   input  logic [7:0]            RAM_Q
);

   typedef enum logic [2:0] {
      C_IDLE = 3'd0,
      C_PEND = 3'd1,
      C_RD1  = 3'd2,
      C_RD2  = 3'd3,
      C_ACK  = 3'd4,
      C_HOLD = 3'd5
   } cpu_state_t;

   cpu_state_t            state_r;
   cpu_state_t            next_state_s;
   logic [ADDR_WIDTH-1:0] cpu_a_r;
   logic [7:0]            cpu_di_r;
   logic                  cpu_rd_r;
   logic                  latch_s;
   logic                  vid_s1_r;
   logic                  vid_s2_r;
   logic                  buf_valid_r;
   logic [ADDR_WIDTH-1:0] buf_a_r;
   logic [7:0]            buf_d_r;
   logic                  grant_vid_s;
   logic                  grant_drain_s;
   logic                  grant_rd_s;
   logic                  grant_wr_s;
   logic                  buf_load_idle_s;
   logic                  buf_load_pend_s;

   // Slot arbitration: video, then buffer drain, then the pending CPU access.
   always_comb begin
      grant_vid_s   = VID_REQ;
      grant_drain_s = buf_valid_r && !VID_REQ;
      grant_rd_s    = (state_r == C_PEND) && cpu_rd_r && !VID_REQ && !buf_valid_r;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
      grant_wr_s      = 1'b0;
      buf_load_idle_s = (state_r == C_IDLE) && CPU_SEL && !CPU_R_W_n && !buf_valid_r;
      buf_load_pend_s = (state_r == C_PEND) && !cpu_rd_r && !buf_valid_r;
`else
      grant_wr_s      = (state_r == C_PEND) && !cpu_rd_r && !VID_REQ;
      buf_load_idle_s = 1'b0;
      buf_load_pend_s = 1'b0;
`endif
   end

   // CPU request FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      latch_s      = 1'b0;
      case (state_r)
         C_IDLE: begin
            if (CPU_SEL) begin
               latch_s = 1'b1;
               if (buf_load_idle_s) begin
                  next_state_s = C_ACK;
               end else begin
                  next_state_s = C_PEND;
               end
            end else begin
               next_state_s = C_IDLE;
            end
         end
         C_PEND: begin
            if (grant_rd_s) begin
               next_state_s = C_RD1;
            end else if (grant_wr_s || buf_load_pend_s) begin
               next_state_s = C_ACK;
            end else begin
               next_state_s = C_PEND;
            end
         end
         C_RD1:   next_state_s = C_RD2;
         C_RD2:   next_state_s = C_ACK;
         C_ACK:   next_state_s = C_HOLD;
         C_HOLD: begin
            if (CPU_SEL) begin
               next_state_s = C_HOLD;
            end else begin
               next_state_s = C_IDLE;
            end
         end
         default: next_state_s = C_IDLE;
      endcase
   end

   // FSM state, request latch and the registered ready/read-data outputs.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r  <= C_IDLE;
         cpu_a_r  <= '0;
         cpu_di_r <= 8'h00;
         cpu_rd_r <= 1'b0;
         CPU_RDY  <= 1'b0;
         CPU_DO   <= 8'h00;
      end else begin
         state_r <= next_state_s;
         CPU_RDY <= (next_state_s == C_ACK);
         if (latch_s) begin
            cpu_a_r  <= CPU_A;
            cpu_di_r <= CPU_DI;
            cpu_rd_r <= CPU_R_W_n;
         end
         if (state_r == C_RD2) begin
            CPU_DO <= RAM_Q;
         end
      end
   end

`ifdef VRAM_ARB_WRITE_BUFFER_EN
   // Posted-write buffer; load and drain are mutually exclusive since each requires the opposite valid state.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         buf_valid_r <= 1'b0;
         buf_a_r     <= '0;
         buf_d_r     <= 8'h00;
      end else if (buf_load_idle_s) begin
         buf_valid_r <= 1'b1;
         buf_a_r     <= CPU_A;
         buf_d_r     <= CPU_DI;
      end else if (buf_load_pend_s) begin
         buf_valid_r <= 1'b1;
         buf_a_r     <= cpu_a_r;
         buf_d_r     <= cpu_di_r;
      end else if (grant_drain_s) begin
         buf_valid_r <= 1'b0;
      end else begin
         buf_valid_r <= buf_valid_r;
      end
   end
`else
   assign buf_valid_r = 1'b0;
   assign buf_a_r     = '0;
   assign buf_d_r     = 8'h00;
`endif

   // Registered RAM port driven by the winning slot; RAM_WE only follows a write grant.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         RAM_A  <= '0;
         RAM_D  <= 8'h00;
         RAM_WE <= 1'b0;
      end else if (grant_vid_s) begin
         RAM_A  <= VID_A;
         RAM_WE <= 1'b0;
      end else if (grant_drain_s) begin
         RAM_A  <= buf_a_r;
         RAM_D  <= buf_d_r;
         RAM_WE <= 1'b1;
      end else if (grant_wr_s) begin
         RAM_A  <= cpu_a_r;
         RAM_D  <= cpu_di_r;
         RAM_WE <= 1'b1;
      end else if (grant_rd_s) begin
         RAM_A  <= cpu_a_r;
         RAM_WE <= 1'b0;
      end else begin
         RAM_WE <= 1'b0;
      end
   end

   // Video read pipeline: address out, RAM access, capture; no back-pressure so reads stream back-to-back.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         vid_s1_r  <= 1'b0;
         vid_s2_r  <= 1'b0;
         VID_VALID <= 1'b0;
         VID_Q     <= 8'h00;
      end else begin
         vid_s1_r  <= grant_vid_s;
         vid_s2_r  <= vid_s1_r;
         VID_VALID <= vid_s2_r;
         if (vid_s2_r) begin
            VID_Q <= RAM_Q;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM model.
// Buffer-specific expectations follow VRAM_ARB_WRITE_BUFFER_EN.
module tb_vram_arbiter;

   localparam int AW = 13;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
   localparam int   WR_LAT    = 0;
   localparam logic WE_AT_RDY = 1'b0;
`else
   localparam int   WR_LAT    = 1;
   localparam logic WE_AT_RDY = 1'b1;
`endif

   logic          CLK = 1'b0;
   logic          RESET_n;
   logic          VID_REQ;
   logic [AW-1:0] VID_A;
   logic [7:0]    VID_Q;
   logic          VID_VALID;
   logic          CPU_SEL;
   logic          CPU_R_W_n;
   logic [AW-1:0] CPU_A;
   logic [7:0]    CPU_DI;
   logic [7:0]    CPU_DO;
   logic          CPU_RDY;
   logic [AW-1:0] RAM_A;
   logic [7:0]    RAM_D;
   logic          RAM_WE;
   logic [7:0]    RAM_Q = 8'h00;

   logic [7:0]    mem [0:(1<<AW)-1];
   logic [AW-1:0] wr_a_q [$];
   logic [7:0]    wr_d_q [$];
   int            tests = 0;
   int            fails = 0;
   int            lat;
   int            n_wr;
   logic          we_seen;

   vram_arbiter #(.ADDR_WIDTH(AW)) dut (
      .CLK(CLK), .RESET_n(RESET_n),
      .VID_REQ(VID_REQ), .VID_A(VID_A), .VID_Q(VID_Q), .VID_VALID(VID_VALID),
      .CPU_SEL(CPU_SEL), .CPU_R_W_n(CPU_R_W_n), .CPU_A(CPU_A), .CPU_DI(CPU_DI),
      .CPU_DO(CPU_DO), .CPU_RDY(CPU_RDY),
      .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RAM_WE) begin
         mem[RAM_A] <= RAM_D;
         wr_a_q.push_back(RAM_A);
         wr_d_q.push_back(RAM_D);
      end
      RAM_Q <= mem[RAM_A];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ram_a", 32'(RAM_A), 32'h0);
      chk("rst_ram_d", 32'(RAM_D), 32'h0);
      chk("rst_ram_we", 32'(RAM_WE), 32'h0);
      chk("rst_vid_q", 32'(VID_Q), 32'h0);
      chk("rst_vid_valid", 32'(VID_VALID), 32'h0);
      chk("rst_cpu_do", 32'(CPU_DO), 32'h0);
      chk("rst_cpu_rdy", 32'(CPU_RDY), 32'h0);
   endtask

   // Issue one CPU access; lat = edges after the request edge until CPU_RDY is seen.
   task automatic cpu_req(input logic rw, input logic [AW-1:0] a, input logic [7:0] d,
                          output int l, output logic we_at);
      CPU_SEL = 1'b1; CPU_R_W_n = rw; CPU_A = a; CPU_DI = d;
      tick();
      l = 0;
      while (!CPU_RDY && l < 40) begin
         tick();
         l++;
      end
      we_at = RAM_WE;
      CPU_SEL = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
      mem[13'h0100] = 8'h41;
      mem[13'h0101] = 8'h42;
      mem[13'h1FFF] = 8'h5A;
      mem[13'h0555] = 8'h99;
      for (int i = 0; i < 5; i++) mem[13'h0200 + 13'(i)] = 8'h10 + 8'(i);
      RESET_n = 1'b0; VID_REQ = 1'b0; VID_A = '0;
      CPU_SEL = 1'b0; CPU_R_W_n = 1'b1; CPU_A = '0; CPU_DI = 8'h00;
      tick(); tick();
      chk_reset_outputs();
      RESET_n = 1'b1;
      tick();

      // Two back-to-back video fetches.
      VID_REQ = 1'b1; VID_A = 13'h0100;
      tick();
      chk("vid_ram_a0", 32'(RAM_A), 32'h0100);
      chk("vid_valid_k", 32'(VID_VALID), 32'h0);
      VID_A = 13'h0101;
      tick();
      chk("vid_ram_a1", 32'(RAM_A), 32'h0101);
      chk("vid_valid_k1", 32'(VID_VALID), 32'h0);
      VID_REQ = 1'b0;
      tick();
      chk("vid_valid_a", 32'(VID_VALID), 32'h1);
      chk("vid_q_a", 32'(VID_Q), 32'h41);
      chk("vid_no_we", 32'(RAM_WE), 32'h0);
      tick();
      chk("vid_valid_b", 32'(VID_VALID), 32'h1);
      chk("vid_q_b", 32'(VID_Q), 32'h42);
      tick();
      chk("vid_valid_end", 32'(VID_VALID), 32'h0);

      // Uncontended CPU read of the top address.
      cpu_req(1'b1, 13'h1FFF, 8'h00, lat, we_seen);
      chk("rd_lat", 32'(lat), 32'd3);
      chk("rd_do_held", 32'(CPU_DO), 32'h5A);
      chk("rd_rdy_low", 32'(CPU_RDY), 32'h0);

      // CPU read contending with five video requests.
      CPU_SEL = 1'b1; CPU_R_W_n = 1'b1; CPU_A = 13'h0555;
      tick();
      chk("cont_rdy_e0", 32'(CPU_RDY), 32'h0);
      for (int e = 1; e <= 10; e++) begin
         VID_REQ = (e <= 5);
         VID_A = 13'h0200 + 13'(e - 1);
         tick();
         chk("cont_vvalid", 32'(VID_VALID), 32'(e >= 3 && e <= 7));
         if (e >= 3 && e <= 7) chk("cont_vq", 32'(VID_Q), 32'(8'h10 + 8'(e - 3)));
         chk("cont_rdy", 32'(CPU_RDY), 32'(e == 8));
         if (e == 6) chk("cont_grant_a", 32'(RAM_A), 32'h0555);
         if (e == 8) begin
            chk("cont_do", 32'(CPU_DO), 32'h99);
            CPU_SEL = 1'b0;
         end
      end

      // Write then read back the same address.
      n_wr = wr_a_q.size();
      cpu_req(1'b0, 13'h0800, 8'hC3, lat, we_seen);
      chk("wr_lat", 32'(lat), 32'(WR_LAT));
      chk("wr_we_at_rdy", 32'(we_seen), 32'(WE_AT_RDY));
      chk("wr_count", 32'(wr_a_q.size() - n_wr), 32'd1);
      if (wr_a_q.size() > n_wr) begin
         chk("wr_addr", 32'(wr_a_q[n_wr]), 32'h0800);
         chk("wr_data", 32'(wr_d_q[n_wr]), 32'hC3);
      end
      cpu_req(1'b1, 13'h0800, 8'h00, lat, we_seen);
      chk("rbw_lat", 32'(lat), 32'd3);
      chk("rbw_do", 32'(CPU_DO), 32'hC3);

`ifdef VRAM_ARB_WRITE_BUFFER_EN
      // Two writes while video owns every slot: second waits for the drain.
      n_wr = wr_a_q.size();
      VID_REQ = 1'b1; VID_A = 13'h0300;
      CPU_SEL = 1'b1; CPU_R_W_n = 1'b0; CPU_A = 13'h0900; CPU_DI = 8'hA1;
      tick();
      chk("bf_first_ack", 32'(CPU_RDY), 32'h1);
      CPU_SEL = 1'b0;
      tick(); tick();
      CPU_SEL = 1'b1; CPU_A = 13'h0901; CPU_DI = 8'hA2;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bf_second_held", 32'(CPU_RDY), 32'h0);
         chk("bf_we_blocked", 32'(RAM_WE), 32'h0);
      end
      VID_REQ = 1'b0;
      tick();
      chk("bf_rdy_at_drain", 32'(CPU_RDY), 32'h0);
      chk("bf_drain1_we", 32'(RAM_WE), 32'h1);
      chk("bf_drain1_a", 32'(RAM_A), 32'h0900);
      chk("bf_drain1_d", 32'(RAM_D), 32'hA1);
      tick();
      chk("bf_second_ack", 32'(CPU_RDY), 32'h1);
      CPU_SEL = 1'b0;
      tick();
      chk("bf_drain2_we", 32'(RAM_WE), 32'h1);
      chk("bf_drain2_a", 32'(RAM_A), 32'h0901);
      chk("bf_drain2_d", 32'(RAM_D), 32'hA2);
      tick(); tick();
      chk("bf_count", 32'(wr_a_q.size() - n_wr), 32'd2);
      if (wr_a_q.size() >= n_wr + 2) begin
         chk("bf_order0", 32'(wr_a_q[n_wr]), 32'h0900);
         chk("bf_order1", 32'(wr_a_q[n_wr + 1]), 32'h0901);
      end
`else
      // Unbuffered write delayed by three video slots.
      CPU_SEL = 1'b1; CPU_R_W_n = 1'b0; CPU_A = 13'h0901; CPU_DI = 8'hA2;
      tick();
      for (int e = 1; e <= 5; e++) begin
         VID_REQ = (e <= 3);
         VID_A = 13'h0300;
         tick();
         chk("wc_rdy", 32'(CPU_RDY), 32'(e == 4));
         chk("wc_we", 32'(RAM_WE), 32'(e == 4));
         if (e == 4) begin
            chk("wc_a", 32'(RAM_A), 32'h0901);
            chk("wc_d", 32'(RAM_D), 32'hA2);
            CPU_SEL = 1'b0;
         end
      end
      tick();
`endif

      // Reset asserted while a write is in flight.
      CPU_SEL = 1'b1; CPU_R_W_n = 1'b0; CPU_A = 13'h0A0A; CPU_DI = 8'h77;
      tick();
      RESET_n = 1'b0;
      n_wr = wr_a_q.size();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_we", 32'(RAM_WE), 32'h0);
      end
      chk_reset_outputs();
      CPU_SEL = 1'b0;
      RESET_n = 1'b1;
      tick(); tick();
      chk("rst_no_write", 32'(wr_a_q.size() - n_wr), 32'd0);
      chk("rst_mem_kept", 32'(mem[13'h0A0A]), 32'h0);
      cpu_req(1'b1, 13'h1FFF, 8'h00, lat, we_seen);
      chk("rst_idle_rd_lat", 32'(lat), 32'd3);
      chk("rst_idle_rd_do", 32'(CPU_DO), 32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
